// File: rtl/decoder_buffered.sv
// Buffered 2-to-3 decoder: FIFO of raw codes, one-hot-ish word decoded from the head entry.
// Latency 1 cycle when empty; in_ready drops at level==DEPTH, out_word holds while out_ready=0.
module decoder_buffered #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [1:0]               in_code,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [2:0]               out_word,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   level,
    output logic [CNT_W-1:0]         word_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {
        S_EMPTY,
        S_PARTIAL,
        S_FULL
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [1:0]      mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW:0]     level_q;
    logic [AW:0]     level_nxt;
    logic            push;
    logic            pop;

    // Handshake flags come straight from the FSM; no bypass in either direction.
    assign in_ready  = (state != S_FULL);
    assign out_valid = (state != S_EMPTY);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign level     = level_q;

    always_comb begin
        level_nxt = level_q;
        state_nxt = state;
        case ({push, pop})
            2'b10:   level_nxt = level_q + (AW+1)'(1);
            2'b01:   level_nxt = level_q - (AW+1)'(1);
            default: level_nxt = level_q;
        endcase
        case (state)
            S_EMPTY: begin
                if (push)
                    state_nxt = (level_nxt == FULL_LVL) ? S_FULL : S_PARTIAL;
            end
            S_PARTIAL: begin
                if (level_nxt == FULL_LVL)
                    state_nxt = S_FULL;
                else if (level_nxt == '0)
                    state_nxt = S_EMPTY;
            end
            S_FULL: begin
                if (pop)
                    state_nxt = S_PARTIAL;
            end
            default: state_nxt = S_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= S_EMPTY;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level_q  <= '0;
            word_cnt <= '0;
        end else begin
            state   <= state_nxt;
            level_q <= level_nxt;
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                rd_ptr   <= rd_ptr + 1'b1;
                word_cnt <= word_cnt + 1'b1;
            end
        end
    end

    // Storage is left uncleared by reset; only the pointers define what is live.
    always_ff @(posedge clk) begin
        if (rst_n && push)
            mem[wr_ptr] <= in_code;
    end

    always_comb begin
        out_word = 3'b000;
        if (out_valid) begin
            case (mem[rd_ptr])
                2'b00: out_word = 3'b000;
                2'b01: out_word = 3'b001;
                2'b10: out_word = 3'b010;
                2'b11: out_word = 3'b100;
                default: out_word = 3'b000;
            endcase
        end
    end

endmodule

// File: doc/decoder_buffered.md
# decoder_buffered

Buffered 2-to-3 decoder, the receive-side counterpart of the team's 3-input priority encoder. It accepts 2-bit codes over a valid/ready handshake and stores them in a small FIFO. It emits the canonical 3-bit word per code, with backpressure. A re-encode of every emitted word returns the original code, so the block closes the encoder loop in loopback benches and downstream consumers.

## Interface
- DEPTH, 4: FIFO entries; power of two, 2..16.
- CNT_W, 16: width of the delivered-word counter.

- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  synchronous reset, active-low; sampled on rising clk edge.
- in_code  input  2  code to decode ({outp[1],outp[0]} of the encoder).
- in_valid  input  1  in_code is valid this cycle.
- in_ready  output  1  block can accept a code this cycle.
- out_word  output  3  decoded word {a,b,c}.
- out_valid  output  1  out_word is valid.
- out_ready  input  1  consumer accepts out_word this cycle.
- level  output  $clog2(DEPTH)+1  current FIFO occupancy.
- word_cnt  output  CNT_W  number of words delivered since reset; wraps.

## Operation
- Decode map, fixed: 00→000, 01→001, 10→010, 11→100.
- Push occurs when in_valid && in_ready. It writes in_code to mem[wr_ptr], and wr_ptr increments modulo DEPTH.
- Pop occurs when out_valid && out_ready. rd_ptr increments modulo DEPTH, and word_cnt increments by 1, wrapping from 2^CNT_W−1 to 0.
- Storage holds the raw 2-bit code. out_word = decode(mem[rd_ptr]) is combinational from the registered head entry.
- in_ready = (level != DEPTH). There is no full-bypass: when full, a simultaneous pop does not raise in_ready in the same cycle.
- out_valid = (level != 0). There is no empty-bypass: a code never reaches out_word in the cycle it is pushed.
- level update:
  - push only: +1
  - pop only: −1
  - push and pop together: unchanged, both pointers advance
  - neither: unchanged
- Control is a three-state FSM derived from level:
  - EMPTY (level=0): push → PARTIAL, or → FULL if DEPTH reaches 1 after the push.
  - PARTIAL: push-only reaching DEPTH → FULL; pop-only reaching 0 → EMPTY; otherwise stay.
  - FULL (level=DEPTH): pop → PARTIAL; push is impossible because in_ready=0.
- in_code and in_valid are ignored while in_ready=0.
- out_word is don't-care while out_valid=0. It is driven as 000 when empty.
- out_word and out_valid must stay stable while out_valid=1 && out_ready=0.

## Timing
- Reset (rst_n=0 at an edge) sets:
  - wr_ptr=0, rd_ptr=0, level=0, word_cnt=0, FSM=EMPTY
  - out_valid=0, out_word=000, in_ready=1
  - FIFO contents are not cleared.
- Reset mid-operation discards all stored codes at that edge. The first push after reset is accepted no earlier than the first edge with rst_n=1.
- Latency: a code pushed at edge N gives out_valid=1 with its word from edge N onward, visible in cycle N+1 when the FIFO was empty. Minimum latency is 1 cycle.
- Throughput: one word per cycle sustained when out_ready=1 and 0<level<DEPTH.
- Pointer wrap: after DEPTH pushes, wr_ptr returns to 0 with no gap or stall.

## Test plan
- Reset then single pushes of 00, 01, 10, 11 with out_ready=1. Required: out_word 000, 001, 010, 100, each valid for one cycle, 1 cycle after its push; word_cnt=4.
- Fill: out_ready=0, push 5 codes 11,10,01,00,11. Required: first 4 accepted; in_ready=0 after the 4th; level=4; 5th not accepted. Then set out_ready=1. Required: words 100,010,001,000 in order, and in_ready=1 one cycle after the first pop.
- Stall: hold out_ready=0 for 3 cycles with level=2. Required: out_word and out_valid unchanged; level stays 2.
- Simultaneous push/pop at level=2 for 10 cycles with a random code stream. Required: level stays 2; outputs match the input order delayed by 2 words; pointers wrap at least twice.
- Reset mid-operation: rst_n=0 for one edge at level=3. Required: level=0, out_valid=0, word_cnt=0, in_ready=1. A following push of 01 yields 001 as the first output.
- Loopback: feed 1000 random codes with random out_ready and re-encode out_word with the priority-encoder model. Required: the re-encoded code sequence equals the input sequence, and word_cnt equals the pop count.
